// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback-port arbiter: register-file
// geometry, the write-port request record and the queued LLU result record.
package wb_pkg;

    localparam int REG_W   = 32;
    localparam int ADDR_W  = 5;
    localparam int REG_NUM = 32;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] waddr;
        logic [REG_W-1:0]  wdata;
    } wb_req_t;

    typedef struct packed {
        logic [ADDR_W-1:0] waddr;
        logic [REG_W-1:0]  wdata;
    } llu_entry_t;

    localparam wb_req_t WB_IDLE = '{we: 1'b0, waddr: '0, wdata: '0};

    // One-hot register mask; address 0 is hardwired and never tracked.
    function automatic logic [REG_NUM-1:0] reg_mask(input logic [ADDR_W-1:0] addr);
        logic [REG_NUM-1:0] mask;
        mask = '0;
        if (addr != '0) mask[addr] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Parameterised synchronous FIFO with registered head, occupancy count and
// asynchronous active-high reset of its control state.
module wb_fifo #(
    parameter  int WIDTH = 37,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && (count != CNT_W'(DEPTH));
    assign do_pop  = pop && (count != '0);
    assign head    = mem[rd_ptr];

    // NOTE: storage has no reset; an entry is only observable once count says
    // it is valid, so clearing the array would just cost reset fan-out.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Merges queued long-latency results into the two register-file write ports
// left idle by pipes 0/1, and tracks which registers still await an LLU write.
module wb_port_arbiter
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    p0_we,
    input  logic [ADDR_W-1:0]       p0_waddr,
    input  logic [REG_W-1:0]        p0_wdata,
    input  logic                    p1_we,
    input  logic [ADDR_W-1:0]       p1_waddr,
    input  logic [REG_W-1:0]        p1_wdata,
    input  logic                    iss_llu,
    input  logic [ADDR_W-1:0]       iss_addr,
    input  logic                    llu_valid,
    input  logic [ADDR_W-1:0]       llu_waddr,
    input  logic [REG_W-1:0]        llu_wdata,
    output logic                    llu_ready,
    output logic                    we1,
    output logic [ADDR_W-1:0]       waddr1,
    output logic [REG_W-1:0]        wdata1,
    output logic                    we2,
    output logic [ADDR_W-1:0]       waddr2,
    output logic [REG_W-1:0]        wdata2,
    output logic [REG_NUM-1:0]      busy,
    output logic [$clog2(DEPTH):0]  llu_cnt
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    llu_entry_t         push_entry;
    llu_entry_t         head;
    logic               push;
    logic               pop;
    logic               head_valid;
    logic               head_zero;
    logic               head_squash;
    logic               grant1;
    logic               grant2;
    wb_req_t            port1;
    wb_req_t            port2;
    logic [REG_NUM-1:0] busy_next;

    assign push_entry.waddr = llu_waddr;
    assign push_entry.wdata = llu_wdata;

    // Ready comes from registered occupancy only, so a same-cycle pop never
    // makes room for a push when full.
    assign llu_ready = (llu_cnt != CNT_W'(DEPTH));
    assign push      = llu_valid && llu_ready;

    wb_fifo #(
        .WIDTH ($bits(llu_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (push_entry),
        .pop   (pop),
        .head  (head),
        .count (llu_cnt)
    );

    assign head_valid  = (llu_cnt != '0);
    assign head_zero   = (head.waddr == '0);
    assign head_squash = (p0_we && (p0_waddr == head.waddr)) ||
                         (p1_we && (p1_waddr == head.waddr));

    // NOTE: every output of this block gets a default first, so no path can
    // leave a value held and infer a latch.
    always_comb begin
        grant1 = 1'b0;
        grant2 = 1'b0;
        pop    = 1'b0;
        if (head_valid) begin
            if (head_zero || head_squash) begin
                pop = 1'b1;
            end else if (!p0_we) begin
                grant1 = 1'b1;
                pop    = 1'b1;
            end else if (!p1_we) begin
                grant2 = 1'b1;
                pop    = 1'b1;
            end
        end
    end

    // Pipe writes pass through unconditionally; gated by rst so the ports
    // fall silent the moment reset asserts.
    always_comb begin
        port1 = WB_IDLE;
        port2 = WB_IDLE;
        if (!rst) begin
            if (p0_we)       port1 = '{we: 1'b1, waddr: p0_waddr,   wdata: p0_wdata};
            else if (grant1) port1 = '{we: 1'b1, waddr: head.waddr, wdata: head.wdata};
            if (p1_we)       port2 = '{we: 1'b1, waddr: p1_waddr,   wdata: p1_wdata};
            else if (grant2) port2 = '{we: 1'b1, waddr: head.waddr, wdata: head.wdata};
        end
    end

    assign we1    = port1.we;
    assign waddr1 = port1.waddr;
    assign wdata1 = port1.wdata;
    assign we2    = port2.we;
    assign waddr2 = port2.waddr;
    assign wdata2 = port2.wdata;

    // Clear is applied before set so a re-issue in the retiring cycle wins.
    always_comb begin
        busy_next = busy;
        if (pop)     busy_next = busy_next & ~reg_mask(head.waddr);
        if (iss_llu) busy_next = busy_next | reg_mask(iss_addr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy <= '0;
        else     busy <= busy_next;
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed corner cases, a vector
// table for port ownership, and a randomized run against a queue-based model.
module tb_wb_port_arbiter;
    import wb_pkg::*;

    localparam int DEPTH = 4;
    localparam logic [31:0] HD  = 32'hC0DE_0001;
    localparam logic [31:0] P0D = 32'h1111_1111;
    localparam logic [31:0] P1D = 32'h2222_2222;

    logic        clk = 1'b0;
    logic        rst;
    logic        p0_we, p1_we, iss_llu, llu_valid;
    logic [4:0]  p0_waddr, p1_waddr, iss_addr, llu_waddr;
    logic [31:0] p0_wdata, p1_wdata, llu_wdata;
    logic        llu_ready, we1, we2;
    logic [4:0]  waddr1, waddr2;
    logic [31:0] wdata1, wdata2, busy;
    logic [2:0]  llu_cnt;

    wb_port_arbiter #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .p0_we(p0_we), .p0_waddr(p0_waddr), .p0_wdata(p0_wdata),
        .p1_we(p1_we), .p1_waddr(p1_waddr), .p1_wdata(p1_wdata),
        .iss_llu(iss_llu), .iss_addr(iss_addr),
        .llu_valid(llu_valid), .llu_waddr(llu_waddr), .llu_wdata(llu_wdata),
        .llu_ready(llu_ready),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .we2(we2), .waddr2(waddr2), .wdata2(wdata2),
        .busy(busy), .llu_cnt(llu_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        p0_we = 1'b0; p0_waddr = '0; p0_wdata = '0;
        p1_we = 1'b0; p1_waddr = '0; p1_wdata = '0;
        iss_llu = 1'b0; iss_addr = '0;
        llu_valid = 1'b0; llu_waddr = '0; llu_wdata = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Port-ownership vectors: one queued head plus a pipe pattern.
    typedef struct {
        logic        p0_we;
        logic [4:0]  p0_a;
        logic        p1_we;
        logic [4:0]  p1_a;
        logic [4:0]  h_a;
        logic        e_we1;
        logic [4:0]  e_a1;
        logic [31:0] e_d1;
        logic        e_we2;
        logic [4:0]  e_a2;
        logic [31:0] e_d2;
        logic [2:0]  e_cnt;
    } vec_t;

    vec_t vecs[9];

    // Reference model state.
    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    ent_t        q[$];
    ent_t        h;
    logic [31:0] busy_m;
    logic        hv, retire, g1, g2, accepted, lv_hold;
    logic        e_we1, e_we2;
    logic [4:0]  e_a1, e_a2, r;
    logic [31:0] e_d1, e_d2;

    initial begin
        vecs[0] = '{1'b0, 5'd0, 1'b0, 5'd0, 5'd5, 1'b1, 5'd5, HD,  1'b0, 5'd0, 32'h0, 3'd0};
        vecs[1] = '{1'b1, 5'd3, 1'b0, 5'd0, 5'd5, 1'b1, 5'd3, P0D, 1'b1, 5'd5, HD,    3'd0};
        vecs[2] = '{1'b0, 5'd0, 1'b1, 5'd4, 5'd5, 1'b1, 5'd5, HD,  1'b1, 5'd4, P1D,   3'd0};
        vecs[3] = '{1'b1, 5'd3, 1'b1, 5'd4, 5'd5, 1'b1, 5'd3, P0D, 1'b1, 5'd4, P1D,   3'd1};
        vecs[4] = '{1'b1, 5'd5, 1'b0, 5'd0, 5'd5, 1'b1, 5'd5, P0D, 1'b0, 5'd0, 32'h0, 3'd0};
        vecs[5] = '{1'b0, 5'd0, 1'b1, 5'd5, 5'd5, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, P1D, 3'd0};
        vecs[6] = '{1'b1, 5'd3, 1'b1, 5'd4, 5'd0, 1'b1, 5'd3, P0D, 1'b1, 5'd4, P1D,   3'd0};
        vecs[7] = '{1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 3'd0};
        vecs[8] = '{1'b1, 5'd0, 1'b0, 5'd0, 5'd6, 1'b1, 5'd0, P0D, 1'b1, 5'd6, HD,    3'd0};

        idle();
        rst = 1'b1;
        #1;
        check("rst_we1", 32'(we1), 32'd0);
        check("rst_we2", 32'(we2), 32'd0);
        check("rst_waddr1", 32'(waddr1), 32'd0);
        check("rst_wdata1", wdata1, 32'd0);
        check("rst_waddr2", 32'(waddr2), 32'd0);
        check("rst_wdata2", wdata2, 32'd0);
        check("rst_cnt", 32'(llu_cnt), 32'd0);
        check("rst_ready", 32'(llu_ready), 32'd1);
        check("rst_busy", busy, 32'd0);
        tick();
        rst = 1'b0;

        // Single result to r5 with both pipes idle.
        llu_valid = 1'b1; llu_waddr = 5'd5; llu_wdata = 32'h1234;
        iss_llu = 1'b1; iss_addr = 5'd5;
        #1 check("t1_busy_pre", 32'(busy[5]), 32'd0);
        tick();
        idle();
        #1;
        check("t1_we1", 32'(we1), 32'd1);
        check("t1_waddr1", 32'(waddr1), 32'd5);
        check("t1_wdata1", wdata1, 32'h1234);
        check("t1_we2", 32'(we2), 32'd0);
        check("t1_busy_set", 32'(busy[5]), 32'd1);
        tick();
        check("t1_busy_clr", 32'(busy[5]), 32'd0);
        check("t1_cnt", 32'(llu_cnt), 32'd0);

        // Fill the FIFO while both pipes own their ports, then drain on port 2.
        p0_we = 1'b1; p0_waddr = 5'd1; p0_wdata = 32'hAAAA_0001;
        p1_we = 1'b1; p1_waddr = 5'd2; p1_wdata = 32'hBBBB_0002;
        for (int i = 0; i < 4; i++) begin
            llu_valid = 1'b1; llu_waddr = 5'(10 + i); llu_wdata = 32'h5000 + 32'(i);
            tick();
        end
        llu_valid = 1'b1; llu_waddr = 5'd20; llu_wdata = 32'hF00D;
        #1;
        check("t2_cnt_full", 32'(llu_cnt), 32'd4);
        check("t2_ready", 32'(llu_ready), 32'd0);
        check("t2_waddr1", 32'(waddr1), 32'd1);
        check("t2_waddr2", 32'(waddr2), 32'd2);
        tick();
        check("t2_full_push_refused", 32'(llu_cnt), 32'd4);
        p1_we = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("t2_drain_we2", 32'(we2), 32'd1);
            check("t2_drain_waddr2", 32'(waddr2), 32'(10 + i));
            check("t2_drain_wdata2", wdata2, 32'h5000 + 32'(i));
            check("t2_drain_cnt", 32'(llu_cnt), 32'(4 - i));
            check("t2_drain_port1", 32'(waddr1), 32'd1);
            tick();
            llu_valid = 1'b0;
        end
        check("t2_empty", 32'(llu_cnt), 32'd0);
        check("t2_we2_idle", 32'(we2), 32'd0);

        // Head r7 squashed by pipe 0 writing r7.
        idle();
        iss_llu = 1'b1; iss_addr = 5'd7;
        tick();
        iss_llu = 1'b0;
        llu_valid = 1'b1; llu_waddr = 5'd7; llu_wdata = 32'h77;
        tick();
        llu_valid = 1'b0;
        p0_we = 1'b1; p0_waddr = 5'd7; p0_wdata = 32'hDEAD_0007;
        #1;
        check("t3_we1", 32'(we1), 32'd1);
        check("t3_wdata1", wdata1, 32'hDEAD_0007);
        check("t3_we2", 32'(we2), 32'd0);
        check("t3_busy_pre", 32'(busy[7]), 32'd1);
        tick();
        p0_we = 1'b0;
        check("t3_cnt", 32'(llu_cnt), 32'd0);
        check("t3_busy_clr", 32'(busy[7]), 32'd0);

        // Re-issue to r9 in the cycle its head retires: set wins.
        iss_llu = 1'b1; iss_addr = 5'd9;
        tick();
        iss_llu = 1'b0;
        llu_valid = 1'b1; llu_waddr = 5'd9; llu_wdata = 32'h99;
        tick();
        llu_valid = 1'b0;
        iss_llu = 1'b1; iss_addr = 5'd9;
        #1;
        check("t4_waddr1", 32'(waddr1), 32'd9);
        tick();
        iss_llu = 1'b0;
        check("t4_busy_kept", 32'(busy[9]), 32'd1);
        check("t4_cnt", 32'(llu_cnt), 32'd0);

        // Result to r0 while both pipes are busy: dropped without a write.
        p0_we = 1'b1; p0_waddr = 5'd1; p0_wdata = P0D;
        p1_we = 1'b1; p1_waddr = 5'd2; p1_wdata = P1D;
        llu_valid = 1'b1; llu_waddr = 5'd0; llu_wdata = 32'hFF;
        tick();
        llu_valid = 1'b0;
        #1;
        check("t5_cnt1", 32'(llu_cnt), 32'd1);
        check("t5_wdata1", wdata1, P0D);
        check("t5_wdata2", wdata2, P1D);
        tick();
        check("t5_cnt0", 32'(llu_cnt), 32'd0);

        // Asynchronous reset with queued entries and busy registers.
        do_reset();
        p0_we = 1'b1; p0_waddr = 5'd1; p0_wdata = P0D;
        p1_we = 1'b1; p1_waddr = 5'd2; p1_wdata = P1D;
        iss_llu = 1'b1; iss_addr = 5'd5;
        tick();
        iss_addr = 5'd7;
        tick();
        iss_llu = 1'b0;
        for (int i = 0; i < 3; i++) begin
            llu_valid = 1'b1; llu_waddr = 5'(20 + i); llu_wdata = 32'(i);
            tick();
        end
        llu_valid = 1'b0;
        #1;
        check("t6_cnt3", 32'(llu_cnt), 32'd3);
        check("t6_busy", busy, 32'h0000_00A0);
        #1 rst = 1'b1;
        #1;
        check("t6_rst_cnt", 32'(llu_cnt), 32'd0);
        check("t6_rst_busy", busy, 32'd0);
        check("t6_rst_we1", 32'(we1), 32'd0);
        check("t6_rst_we2", 32'(we2), 32'd0);
        tick();
        rst = 1'b0;
        idle();

        // Vector table.
        foreach (vecs[i]) begin
            do_reset();
            llu_valid = 1'b1; llu_waddr = vecs[i].h_a; llu_wdata = HD;
            tick();
            llu_valid = 1'b0;
            p0_we = vecs[i].p0_we; p0_waddr = vecs[i].p0_a; p0_wdata = P0D;
            p1_we = vecs[i].p1_we; p1_waddr = vecs[i].p1_a; p1_wdata = P1D;
            #1;
            check($sformatf("vec%0d_we1", i), 32'(we1), 32'(vecs[i].e_we1));
            check($sformatf("vec%0d_we2", i), 32'(we2), 32'(vecs[i].e_we2));
            if (vecs[i].e_we1) begin
                check($sformatf("vec%0d_waddr1", i), 32'(waddr1), 32'(vecs[i].e_a1));
                check($sformatf("vec%0d_wdata1", i), wdata1, vecs[i].e_d1);
            end
            if (vecs[i].e_we2) begin
                check($sformatf("vec%0d_waddr2", i), 32'(waddr2), 32'(vecs[i].e_a2));
                check($sformatf("vec%0d_wdata2", i), wdata2, vecs[i].e_d2);
            end
            tick();
            check($sformatf("vec%0d_cnt", i), 32'(llu_cnt), 32'(vecs[i].e_cnt));
        end

        // Randomized run against the queue model.
        do_reset();
        q.delete();
        busy_m  = '0;
        lv_hold = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            p0_we = 1'($urandom_range(0, 1)); p0_waddr = 5'($urandom_range(0, 7)); p0_wdata = $urandom;
            p1_we = 1'($urandom_range(0, 1)); p1_waddr = 5'($urandom_range(0, 7)); p1_wdata = $urandom;
            if (!lv_hold) begin
                llu_valid = ($urandom_range(0, 1) == 1);
                llu_waddr = 5'($urandom_range(0, 7));
                llu_wdata = $urandom;
            end
            iss_llu = 1'b0; iss_addr = '0;
            if ($urandom_range(0, 3) == 0) begin
                for (int k = 0; k < 8; k++) begin
                    r = 5'($urandom_range(1, 31));
                    if (!busy_m[r]) begin
                        iss_llu = 1'b1; iss_addr = r;
                        break;
                    end
                end
            end
            if (iss_llu && busy_m[iss_addr]) begin
                errors++;
                $display("FAIL rnd_iss_to_busy: got r%0d busy expected idle", iss_addr);
            end
            #2;

            hv = (q.size() > 0);
            h  = hv ? q[0] : '{5'd0, 32'd0};
            retire = 1'b0; g1 = 1'b0; g2 = 1'b0;
            if (hv) begin
                if (h.a == 5'd0 || (p0_we && p0_waddr == h.a) || (p1_we && p1_waddr == h.a))
                    retire = 1'b1;
                else if (!p0_we) begin g1 = 1'b1; retire = 1'b1; end
                else if (!p1_we) begin g2 = 1'b1; retire = 1'b1; end
            end
            e_we1 = p0_we || g1;
            e_a1  = p0_we ? p0_waddr : h.a;
            e_d1  = p0_we ? p0_wdata : h.d;
            e_we2 = p1_we || g2;
            e_a2  = p1_we ? p1_waddr : h.a;
            e_d2  = p1_we ? p1_wdata : h.d;

            check("rnd_we1", 32'(we1), 32'(e_we1));
            check("rnd_we2", 32'(we2), 32'(e_we2));
            if (e_we1) begin
                check("rnd_waddr1", 32'(waddr1), 32'(e_a1));
                check("rnd_wdata1", wdata1, e_d1);
            end
            if (e_we2) begin
                check("rnd_waddr2", 32'(waddr2), 32'(e_a2));
                check("rnd_wdata2", wdata2, e_d2);
            end
            check("rnd_cnt", 32'(llu_cnt), 32'(q.size()));
            check("rnd_ready", 32'(llu_ready), 32'(q.size() < DEPTH));
            check("rnd_busy", busy, busy_m);

            accepted = llu_valid && (q.size() < DEPTH);
            if (retire) begin
                busy_m[h.a] = 1'b0;
                void'(q.pop_front());
            end
            if (iss_llu && iss_addr != 5'd0) busy_m[iss_addr] = 1'b1;
            if (accepted) q.push_back('{llu_waddr, llu_wdata});
            lv_hold = llu_valid && !accepted;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
